// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with 16x oversampling, framing/overflow flags
// and a small receive FIFO exposing its head combinationally.
module uart_rx_fifo #(
   parameter int FIFO_DEPTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx,
   input  logic [31:0] clkdiv,
   input  logic        re,
   output logic [31:0] si,
   output logic        rdy,
   output logic        ferr,
   output logic        ovf,
   input  logic        clr
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxs;

   logic [31:0] tcnt_q;
   logic        tick;

   state_t     state_q, state_d;
   logic [3:0] tc_q, tc_d;
   logic [2:0] bi_q, bi_d;
   logic [7:0] sh_q, sh_d;
   logic       push;
   logic       ferr_set;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [AW:0]   cnt_q;
   logic          full;
   logic          do_pop;
   logic          do_push;
   logic          ovf_set;

   // metastability guard; idle-high so reset loads ones
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      end
   end

   assign rxs = sync_q[SYNC_STAGES-1];

   assign tick = (tcnt_q == 32'd0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tcnt_q <= '0;
      end else if (tick) begin
         tcnt_q <= clkdiv;
      end else begin
         tcnt_q <= tcnt_q - 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         tc_q    <= '0;
         bi_q    <= '0;
         sh_q    <= '0;
      end else begin
         state_q <= state_d;
         tc_q    <= tc_d;
         bi_q    <= bi_d;
         sh_q    <= sh_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      tc_d     = tc_q;
      bi_d     = bi_q;
      sh_d     = sh_q;
      push     = 1'b0;
      ferr_set = 1'b0;
      if (tick) begin
         unique case (state_q)
            ST_IDLE: begin
               if (!rxs) begin
                  state_d = ST_START;
                  tc_d    = '0;
               end
            end
            ST_START: begin
               // 8th tick lands mid start bit; high there is a glitch
               if (tc_q == 4'd7) begin
                  tc_d = '0;
                  if (!rxs) begin
                     state_d = ST_DATA;
                     bi_d    = '0;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  tc_d = tc_q + 4'd1;
               end
            end
            ST_DATA: begin
               if (tc_q == 4'd15) begin
                  tc_d       = '0;
                  sh_d[bi_q] = rxs;
                  if (bi_q == 3'd7) begin
                     state_d = ST_STOP;
                  end else begin
                     bi_d = bi_q + 3'd1;
                  end
               end else begin
                  tc_d = tc_q + 4'd1;
               end
            end
            ST_STOP: begin
               if (tc_q == 4'd15) begin
                  tc_d = '0;
                  if (rxs) begin
                     push    = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     ferr_set = 1'b1;
                     state_d  = ST_BREAK;
                  end
               end else begin
                  tc_d = tc_q + 4'd1;
               end
            end
            ST_BREAK: begin
               if (rxs) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign rdy     = (cnt_q != '0);
   assign full    = (cnt_q == FULL_CNT);
   assign do_pop  = re && rdy;
   // a same-cycle pop frees the slot a full FIFO needs
   assign do_push = push && (!full || do_pop);
   assign ovf_set = push && full && !do_pop;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            wp_q <= wp_q + AW'(1);
         end
         if (do_pop) begin
            rp_q <= rp_q + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wp_q] <= sh_q;
      end
   end

   assign si = rdy ? {24'h0, mem[rp_q]} : 32'hFFFF_FFFF;

   // a same-cycle set beats clr
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ferr <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         if (ferr_set) begin
            ferr <= 1'b1;
         end else if (clr) begin
            ferr <= 1'b0;
         end
         if (ovf_set) begin
            ovf <= 1'b1;
         end else if (clr) begin
            ovf <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized self-checking bench for uart_rx_fifo against a
// frame-level queue model of the receiver and FIFO.
module tb_uart_rx_fifo;

   localparam int DEPTH = 8;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        rx     = 1'b1;
   logic        re     = 1'b0;
   logic        clr    = 1'b0;
   logic [31:0] clkdiv = 32'd3;
   logic [31:0] si;
   logic        rdy;
   logic        ferr;
   logic        ovf;

   int checks = 0;
   int errors = 0;

   logic [7:0] q[$];
   logic       ferr_m = 1'b0;
   logic       ovf_m  = 1'b0;

   uart_rx_fifo #(
      .FIFO_DEPTH(DEPTH),
      .SYNC_STAGES(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .rx(rx),
      .clkdiv(clkdiv),
      .re(re),
      .si(si),
      .rdy(rdy),
      .ferr(ferr),
      .ovf(ovf),
      .clr(clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic check_state(input string tag);
      logic [31:0] exp_si;
      exp_si = (q.size() != 0) ? {24'h0, q[0]} : 32'hFFFF_FFFF;
      check({tag, ":rdy"}, {31'b0, rdy}, {31'b0, q.size() != 0});
      check({tag, ":si"}, si, exp_si);
      check({tag, ":ferr"}, {31'b0, ferr}, {31'b0, ferr_m});
      check({tag, ":ovf"}, {31'b0, ovf}, {31'b0, ovf_m});
   endtask

   // frame outcome: clr first, then pop, then the push or error
   task automatic model_frame(input logic [7:0] d, input logic ok,
                              input logic popped, input logic cleared);
      if (cleared) begin
         ferr_m = 1'b0;
         ovf_m  = 1'b0;
      end
      if (popped && q.size() != 0) void'(q.pop_front());
      if (!ok) ferr_m = 1'b1;
      else if (q.size() < DEPTH) q.push_back(d);
      else ovf_m = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic ok,
                             input int hold);
      int bp;
      bp = 16 * (int'(clkdiv) + 1);
      @(negedge clk);
      rx = 1'b0;
      repeat (bp) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (bp) @(negedge clk);
      end
      rx = ok;
      repeat (bp + hold) @(negedge clk);
      rx = 1'b1;
      repeat (2 * bp) @(negedge clk);
   endtask

   task automatic pop(input string tag);
      @(negedge clk);
      check_state(tag);
      re = 1'b1;
      @(negedge clk);
      re = 1'b0;
      if (q.size() != 0) void'(q.pop_front());
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      ferr_m = 1'b0;
      ovf_m  = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      rx    = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      ferr_m = 1'b0;
      ovf_m  = 1'b0;
   endtask

   // raise re/clr exactly on the cycle a byte is pushed
   task automatic push_strobe(input logic r, input logic c,
                              output logic hit, output logic [31:0] h);
      hit = 1'b0;
      h   = '0;
      for (int n = 0; n < 4000 && !hit; n++) begin
         @(negedge clk);
         if (dut.push) begin
            hit = 1'b1;
            h   = si;
            re  = r;
            clr = c;
         end
      end
      @(posedge clk);
      #1;
      re  = 1'b0;
      clr = 1'b0;
   endtask

   task automatic strobe_frame(input string tag, input logic [7:0] d,
                               input logic r, input logic c);
      logic        hit;
      logic [31:0] h;
      fork
         send_frame(d, 1'b1, 0);
         push_strobe(r, c, hit, h);
      join
      check({tag, ":push_seen"}, {31'b0, hit}, 32'd1);
      if (r && q.size() != 0) check({tag, ":head"}, h, {24'h0, q[0]});
      model_frame(d, 1'b1, r, c);
      @(negedge clk);
      check_state(tag);
   endtask

   initial begin
      logic [7:0] d;
      logic       ok;
      int         bp;

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_state("reset");

      clkdiv = 32'd3;
      send_frame(8'hA5, 1'b1, 0);
      model_frame(8'hA5, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check_state("a5");
      pop("a5_pop");
      @(negedge clk);
      check_state("a5_empty");

      @(negedge clk);
      rx = 1'b0;
      repeat (20) @(negedge clk);
      rx = 1'b1;
      repeat (200) @(negedge clk);
      check_state("glitch");
      send_frame(8'h96, 1'b1, 0);
      model_frame(8'h96, 1'b1, 1'b0, 1'b0);
      check_state("after_glitch");
      pop("glitch_pop");

      send_frame(8'h3C, 1'b0, 1000);
      model_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      check_state("break");
      send_frame(8'h11, 1'b1, 0);
      model_frame(8'h11, 1'b1, 1'b0, 1'b0);
      check_state("after_break");
      pulse_clr();
      check_state("ferr_clr");
      pop("brk_pop");

      for (int i = 0; i < 9; i++) begin
         send_frame(8'(i), 1'b1, 0);
         model_frame(8'(i), 1'b1, 1'b0, 1'b0);
      end
      check_state("ovf");
      for (int i = 0; i < 8; i++) pop("ovf_pop");
      @(negedge clk);
      check_state("ovf_drained");
      pulse_clr();
      check_state("ovf_clr");

      for (int i = 0; i < 8; i++) begin
         send_frame(8'(i), 1'b1, 0);
         model_frame(8'(i), 1'b1, 1'b0, 1'b0);
      end
      check_state("full");
      strobe_frame("full_pushpop", 8'h08, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) pop("pp_pop");
      @(negedge clk);
      check_state("pp_drained");

      for (int i = 0; i < 8; i++) begin
         send_frame(8'(8'h20 + i), 1'b1, 0);
         model_frame(8'(8'h20 + i), 1'b1, 1'b0, 1'b0);
      end
      strobe_frame("clr_vs_set", 8'h99, 1'b0, 1'b1);
      pulse_clr();
      check_state("clr_after");
      for (int i = 0; i < 8; i++) pop("cs_pop");

      strobe_frame("empty_pushpop", 8'h42, 1'b1, 1'b0);
      pop("ep_pop");

      send_frame(8'h77, 1'b1, 0);
      model_frame(8'h77, 1'b1, 1'b0, 1'b0);
      send_frame(8'hE1, 1'b0, 0);
      model_frame(8'hE1, 1'b0, 1'b0, 1'b0);
      check_state("pre_rst");
      bp = 16 * (int'(clkdiv) + 1);
      @(negedge clk);
      rx = 1'b0;
      repeat (bp) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = 1'(8'hC3 >> i);
         repeat (bp) @(negedge clk);
      end
      rx = 1'b0;
      repeat (bp / 2) @(negedge clk);
      do_reset();
      repeat (3 * bp) @(negedge clk);
      check_state("mid_rst");
      send_frame(8'h5A, 1'b1, 0);
      model_frame(8'h5A, 1'b1, 1'b0, 1'b0);
      check_state("post_rst");
      pop("post_rst_pop");

      do_reset();
      for (int it = 0; it < 30; it++) begin
         clkdiv = 32'($urandom_range(0, 3));
         d  = 8'($urandom);
         ok = ($urandom_range(0, 7) != 0);
         send_frame(d, ok, int'($urandom_range(0, 50)));
         model_frame(d, ok, 1'b0, 1'b0);
         check_state("rnd");
         repeat ($urandom_range(0, 3)) pop("rnd_pop");
         if ($urandom_range(0, 5) == 0) begin
            pulse_clr();
            check_state("rnd_clr");
         end
      end
      while (q.size() != 0) pop("final_pop");
      @(negedge clk);
      check_state("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
